// File: rtl/alu_pkg.sv
// Shared constants and the registered result record for the subtract stage.
package alu_pkg;

    localparam int DEF_WIDTH = 32;
    localparam int DEF_CNT_W = 16;

    // Widest operand the result record can carry. The record cannot follow a
    // module parameter, so the magnitude field is sized for the widest use and
    // narrower instances keep the unused upper bits at zero.
    localparam int MAG_MAX_W = 64;

    typedef struct packed {
        logic [MAG_MAX_W-1:0] mag;
        logic                 sgn;
        logic                 zero;
    } res_t;

endpackage

// File: rtl/n_bit_sub.sv
// Unsigned magnitude subtractor: |a - b| and a flag for a < b.
module n_bit_sub #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic [WIDTH-1:0] mag_o,
    output logic             sgn_o
);

    // Always subtract the smaller operand from the larger so the result is exact.
    always_comb begin
        sgn_o = (a_i < b_i);
        mag_o = sgn_o ? (b_i - a_i) : (a_i - b_i);
    end

endmodule

// File: rtl/alu_sub_stage.sv
// Two-stage valid/ready subtract stage: S1 captures operands, S2 holds the
// registered magnitude/sign/zero result. Also counts consumed results.
module alu_sub_stage
    import alu_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_mag,
    output logic             out_sgn,
    output logic             out_zero,
    output logic [CNT_W-1:0] op_count,
    output logic             busy
);

    if (WIDTH > MAG_MAX_W) begin : g_bad_width
        $error("alu_sub_stage: WIDTH exceeds the result record magnitude field");
    end

    logic             s1_vld_q, s1_vld_d;
    logic [WIDTH-1:0] s1_a_q, s1_a_d;
    logic [WIDTH-1:0] s1_b_q, s1_b_d;
    logic             s2_vld_q, s2_vld_d;
    res_t             s2_res_q, s2_res_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic             s2_adv;
    logic             s1_load;
    logic             out_xfer;
    logic [WIDTH-1:0] sub_mag;
    logic             sub_sgn;
    logic             sub_zero;

    n_bit_sub #(
        .WIDTH (WIDTH)
    ) u_sub (
        .a_i   (s1_a_q),
        .b_i   (s1_b_q),
        .mag_o (sub_mag),
        .sgn_o (sub_sgn)
    );

    // Zero flag sits beside the subtractor; sign is already 0 when equal.
    assign sub_zero = (sub_mag == '0);

    // Handshake control: S2 moves when empty or drained, S1 moves when empty or S2 moves.
    always_comb begin
        s2_adv   = !s2_vld_q || out_ready;
        in_ready = !s1_vld_q || s2_adv;
        s1_load  = in_valid && in_ready;
        out_xfer = s2_vld_q && out_ready;
    end

    // Next-state for both stages and the consumed-result counter.
    always_comb begin
        s1_vld_d = s1_vld_q;
        s1_a_d   = s1_a_q;
        s1_b_d   = s1_b_q;
        s2_vld_d = s2_vld_q;
        s2_res_d = s2_res_q;
        cnt_d    = cnt_q;
        if (in_ready) begin
            s1_vld_d = in_valid;
        end
        if (s1_load) begin
            s1_a_d = in_a;
            s1_b_d = in_b;
        end
        if (s2_adv) begin
            s2_vld_d      = s1_vld_q;
            s2_res_d.mag  = MAG_MAX_W'(sub_mag);
            s2_res_d.sgn  = sub_sgn;
            s2_res_d.zero = sub_zero;
        end
        if (out_xfer) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Pipeline and counter registers; reset wipes everything in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_vld_q <= 1'b0;
            s1_a_q   <= '0;
            s1_b_q   <= '0;
            s2_vld_q <= 1'b0;
            s2_res_q <= '0;
            cnt_q    <= '0;
        end else begin
            s1_vld_q <= s1_vld_d;
            s1_a_q   <= s1_a_d;
            s1_b_q   <= s1_b_d;
            s2_vld_q <= s2_vld_d;
            s2_res_q <= s2_res_d;
            cnt_q    <= cnt_d;
        end
    end

    if (WIDTH < MAG_MAX_W) begin : g_mag_hi
        logic unused_mag_hi;
        assign unused_mag_hi = |s2_res_q.mag[MAG_MAX_W-1:WIDTH];
    end

    assign out_valid = s2_vld_q;
    assign out_mag   = s2_res_q.mag[WIDTH-1:0];
    assign out_sgn   = s2_res_q.sgn;
    assign out_zero  = s2_res_q.zero;
    assign op_count  = cnt_q;
    assign busy      = s1_vld_q || s2_vld_q;

endmodule

// File: tb/tb_alu_sub_stage.sv
// Bench for alu_sub_stage at WIDTH=8: directed literal cases plus random
// traffic checked every cycle against a queue-based transaction model.
module tb_alu_sub_stage;

    localparam int W  = 8;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_a;
    logic [W-1:0]  in_b;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_mag;
    logic          out_sgn;
    logic          out_zero;
    logic [CW-1:0] op_count;
    logic          busy;

    alu_sub_stage #(
        .WIDTH (W),
        .CNT_W (CW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_mag   (out_mag),
        .out_sgn   (out_sgn),
        .out_zero  (out_zero),
        .op_count  (op_count),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    endtask

    // Transaction model: every accepted pair waits in order; a pair becomes
    // visible two cycles after acceptance and leaves when consumed.
    typedef struct {
        int a;
        int b;
        int stamp;
    } item_t;

    item_t q[$];
    int    cyc   = 0;
    int    ocnt  = 0;
    bit    chk_en = 1'b0;

    always @(negedge clk) begin
        if (chk_en) begin
            bit exp_rdy;
            bit exp_vld;
            int d;
            exp_rdy = (q.size() < 2) || out_ready;
            exp_vld = (q.size() > 0) && (cyc - q[0].stamp >= 2);
            chk("m_in_ready", 32'(in_ready), 32'(exp_rdy));
            chk("m_out_valid", 32'(out_valid), 32'(exp_vld));
            chk("m_busy", 32'(busy), 32'(q.size() > 0));
            chk("m_op_count", 32'(op_count), ocnt & 32'hFFFF);
            if (exp_vld && out_valid) begin
                d = q[0].a - q[0].b;
                chk("m_out_mag", 32'(out_mag), (d < 0) ? -d : d);
                chk("m_out_sgn", 32'(out_sgn), 32'(d < 0));
                chk("m_out_zero", 32'(out_zero), 32'(d == 0));
            end
            if (out_valid && out_ready) begin
                void'(q.pop_front());
                ocnt++;
            end
            if (in_valid && in_ready) q.push_back('{int'(in_a), int'(in_b), cyc});
            cyc++;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic rand_pair();
        int r;
        r = $urandom_range(0, 7);
        in_a = W'($urandom_range(0, 255));
        if (r == 0) in_b = in_a;
        else if (r == 1) begin in_a = '0; in_b = '1; end
        else if (r == 2) begin in_a = '1; in_b = '0; end
        else in_b = W'($urandom_range(0, 255));
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_a      = '0;
        in_b      = '0;
        #2;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_mag", 32'(out_mag), 32'd0);
        chk("rst_out_sgn", 32'(out_sgn), 32'd0);
        chk("rst_out_zero", 32'(out_zero), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_op_count", 32'(op_count), 32'd0);
        step();
        step();
        rst = 1'b0;
        chk_en = 1'b1;

        // a=9, b=5: result two cycles later, count bumps the cycle after.
        in_valid = 1'b1; in_a = 8'd9; in_b = 8'd5; out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        chk("d1_valid", 32'(out_valid), 32'd1);
        chk("d1_mag", 32'(out_mag), 32'd4);
        chk("d1_sgn", 32'(out_sgn), 32'd0);
        chk("d1_zero", 32'(out_zero), 32'd0);
        chk("d1_cnt_before", 32'(op_count), 32'd0);
        step();
        chk("d1_cnt_after", 32'(op_count), 32'd1);
        chk("d1_valid_gone", 32'(out_valid), 32'd0);

        // Back-to-back negative results.
        in_valid = 1'b1; in_a = 8'd5; in_b = 8'd9;
        step();
        in_a = 8'd0; in_b = 8'd255;
        step();
        in_valid = 1'b0;
        chk("d2_mag0", 32'(out_mag), 32'd4);
        chk("d2_sgn0", 32'(out_sgn), 32'd1);
        step();
        chk("d2_valid1", 32'(out_valid), 32'd1);
        chk("d2_mag1", 32'(out_mag), 32'd255);
        chk("d2_sgn1", 32'(out_sgn), 32'd1);
        step();
        chk("d2_cnt", 32'(op_count), 32'd3);

        // Equal operands.
        in_valid = 1'b1; in_a = 8'h7F; in_b = 8'h7F;
        step();
        in_valid = 1'b0;
        step();
        chk("d3_valid", 32'(out_valid), 32'd1);
        chk("d3_mag", 32'(out_mag), 32'd0);
        chk("d3_sgn", 32'(out_sgn), 32'd0);
        chk("d3_zero", 32'(out_zero), 32'd1);
        step();

        // Backpressure: three pairs offered, two accepted, then drained in order.
        out_ready = 1'b0;
        in_valid = 1'b1; in_a = 8'd20; in_b = 8'd3;
        chk("bp_rdy0", 32'(in_ready), 32'd1);
        step();
        chk("bp_rdy1", 32'(in_ready), 32'd1);
        in_a = 8'd3; in_b = 8'd30;
        step();
        chk("bp_rdy2", 32'(in_ready), 32'd0);
        in_a = 8'd200; in_b = 8'd1;
        chk("bp_hold_mag", 32'(out_mag), 32'd17);
        step();
        step();
        chk("bp_rdy_stall", 32'(in_ready), 32'd0);
        chk("bp_stall_valid", 32'(out_valid), 32'd1);
        chk("bp_stall_mag", 32'(out_mag), 32'd17);
        chk("bp_stall_sgn", 32'(out_sgn), 32'd0);
        out_ready = 1'b1;
        #1;
        chk("bp_rdy_release", 32'(in_ready), 32'd1);
        step();
        in_valid = 1'b0;
        chk("bp_out1_mag", 32'(out_mag), 32'd27);
        chk("bp_out1_sgn", 32'(out_sgn), 32'd1);
        step();
        chk("bp_out2_valid", 32'(out_valid), 32'd1);
        chk("bp_out2_mag", 32'(out_mag), 32'd199);
        step();
        chk("bp_drained", 32'(out_valid), 32'd0);

        // Random traffic with random backpressure.
        for (int i = 0; i < 2000; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            rand_pair();
            step();
        end

        // Fill both stages, then reset asynchronously between clock edges.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        rand_pair();
        step();
        step();
        step();
        chk("pre_rst_busy", 32'(busy), 32'd1);
        chk("pre_rst_valid", 32'(out_valid), 32'd1);
        chk_en = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        chk("arst_out_valid", 32'(out_valid), 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_op_count", 32'(op_count), 32'd0);
        chk("arst_in_ready", 32'(in_ready), 32'd1);
        chk("arst_out_mag", 32'(out_mag), 32'd0);
        in_valid = 1'b0;
        step();
        chk("arst_hold_valid", 32'(out_valid), 32'd0);
        #2;
        rst = 1'b0;
        q.delete();
        ocnt = 0;
        step();
        chk("post_rst_busy", 32'(busy), 32'd0);
        chk_en = 1'b1;

        // Counter wrap: 65535 results bring it to 0xFFFF, one more wraps to 0.
        out_ready = 1'b1;
        in_valid  = 1'b1;
        for (int i = 0; i < 65535; i++) begin
            rand_pair();
            step();
        end
        in_valid = 1'b0;
        step();
        step();
        chk("wrap_ffff", 32'(op_count), 32'hFFFF);
        in_valid = 1'b1; in_a = 8'd1; in_b = 8'd2;
        step();
        in_valid = 1'b0;
        step();
        chk("wrap_last_mag", 32'(out_mag), 32'd1);
        step();
        chk("wrap_zero", 32'(op_count), 32'd0);
        step();

        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
